// File: rtl/sat_pkg.sv
// Shared helpers for the signed saturating arithmetic blocks: op mode type and
// the two's-complement extreme values for an arbitrary width.
package sat_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_t;

    // Bit patterns are returned zero-extended; callers truncate to w bits.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/signed_sat_addsub.sv
// Combinational signed add/subtract of a narrow sample onto a wide base, with
// overflow detection and optional saturation to the ACC_W range.
module signed_sat_addsub
    import sat_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] base,
    input  logic [IN_W-1:0]  x,
    input  op_mode_t         op,
    input  logic             sat,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] MAX_POS = ACC_W'(max_pos(ACC_W));
    localparam logic [ACC_W-1:0] MIN_NEG = ACC_W'(min_neg(ACC_W));

    logic [ACC_W:0] base_ext;
    logic [ACC_W:0] x_ext;
    logic [ACC_W:0] r;

    // One guard bit is enough to hold any sum or difference exactly,
    // including negating the most negative sample.
    assign base_ext = {base[ACC_W-1], base};
    assign x_ext    = {{(ACC_W + 1 - IN_W){x[IN_W-1]}}, x};
    assign r        = (op == OP_SUB) ? (base_ext - x_ext) : (base_ext + x_ext);
    assign ovf      = r[ACC_W] ^ r[ACC_W-1];

    always_comb begin
        result = r[ACC_W-1:0];
        if (ovf && sat) begin
            result = r[ACC_W] ? MIN_NEG : MAX_POS;
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Streaming signed accumulator with valid/ready handshakes, per-op saturate or
// wrap, a per-result overflow flag and a sticky overflow bit.
module signed_sat_accumulator
    import sat_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sub,
    input  logic                 sat_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic                 sticky_ovf
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH-1:0] result;
    logic                 ovf;
    logic                 accept;
    op_mode_t             op;

    // The output register frees up in the same cycle it is consumed.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign base     = clear ? '0 : acc;
    assign op       = in_sub ? OP_SUB : OP_ADD;

    signed_sat_addsub #(
        .IN_W  (WIDTH),
        .ACC_W (ACC_WIDTH)
    ) u_addsub (
        .base   (base),
        .x      (in_data),
        .op     (op),
        .sat    (sat_mode),
        .result (result),
        .ovf    (ovf)
    );

    // Clear only affects the running state; a pending result stays intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_ovf    <= 1'b0;
            sticky_ovf <= 1'b0;
        end else if (accept) begin
            acc        <= result;
            out_data   <= result;
            out_ovf    <= ovf;
            out_valid  <= 1'b1;
            sticky_ovf <= (clear ? 1'b0 : sticky_ovf) | ovf;
        end else begin
            if (clear) begin
                acc        <= '0;
                sticky_ovf <= 1'b0;
            end
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Scoreboard bench driving an 8/8 and an 8/12 accumulator with identical stimulus.
module tb_signed_sat_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sub;
    logic       sat_mode;
    logic       out_ready;

    logic        in_ready8, out_valid8, out_ovf8, sticky8;
    logic [7:0]  out_data8;
    logic        in_ready12, out_valid12, out_ovf12, sticky12;
    logic [11:0] out_data12;

    logic               ir [2];
    logic               ov [2];
    logic               oo [2];
    logic               so [2];
    logic signed [63:0] od [2];

    typedef struct {
        longint data0;
        longint data1;
        bit     ovf0;
        bit     ovf1;
    } exp_t;

    exp_t   sb_q[$];
    int     accw [2] = '{8, 12};
    longint m_acc [2];
    bit     m_sticky [2];
    bit     initialized;
    int     checks;
    int     errors;

    signed_sat_accumulator #(.WIDTH(8), .ACC_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_sub(in_sub), .sat_mode(sat_mode), .out_valid(out_valid8),
        .out_ready(out_ready), .out_data(out_data8), .out_ovf(out_ovf8), .sticky_ovf(sticky8)
    );

    signed_sat_accumulator #(.WIDTH(8), .ACC_WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready12),
        .in_data(in_data), .in_sub(in_sub), .sat_mode(sat_mode), .out_valid(out_valid12),
        .out_ready(out_ready), .out_data(out_data12), .out_ovf(out_ovf12), .sticky_ovf(sticky12)
    );

    assign ir[0] = in_ready8;
    assign ir[1] = in_ready12;
    assign ov[0] = out_valid8;
    assign ov[1] = out_valid12;
    assign oo[0] = out_ovf8;
    assign oo[1] = out_ovf12;
    assign so[0] = sticky8;
    assign so[1] = sticky12;
    assign od[0] = 64'(signed'(out_data8));
    assign od[1] = 64'(signed'(out_data12));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference arithmetic on plain integers, clamping or wrapping to w bits.
    function automatic void model_op(input int w, input longint base, input longint x,
                                     input bit sub, input bit sat,
                                     output longint res, output bit ovf);
        longint r, maxv, minv, span;
        span = longint'(1) << w;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -maxv - 1;
        r    = sub ? base - x : base + x;
        ovf  = (r > maxv) || (r < minv);
        if (!ovf) begin
            res = r;
        end else if (sat) begin
            res = (r > maxv) ? maxv : minv;
        end else begin
            res = r & (span - 1);
            if (res > maxv) res = res - span;
        end
    endfunction

    // Drive one cycle of inputs just after a falling edge, check, then advance.
    task automatic applyStimulus(input bit r, input bit c, input bit v, input int d,
                                 input bit s, input bit sm, input bit ordy);
        exp_t   e;
        exp_t   head;
        longint res;
        longint base;
        bit     ovf;
        bit     accept;
        rst       = r;
        clear     = c;
        in_valid  = v;
        in_data   = 8'(d);
        in_sub    = s;
        sat_mode  = sm;
        out_ready = ordy;
        #1;
        if (initialized) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("in_ready%0d", accw[i]), 64'(ir[i]),
                            64'(sb_q.size() == 0 || ordy));
                checkOutput($sformatf("out_valid%0d", accw[i]), 64'(ov[i]),
                            64'(sb_q.size() != 0));
                if (sb_q.size() != 0) begin
                    head = sb_q[0];
                    checkOutput($sformatf("out_data%0d", accw[i]), od[i],
                                (i == 0) ? head.data0 : head.data1);
                    checkOutput($sformatf("out_ovf%0d", accw[i]), 64'(oo[i]),
                                64'((i == 0) ? head.ovf0 : head.ovf1));
                end
            end
        end
        if (r) begin
            sb_q.delete();
            m_acc    = '{0, 0};
            m_sticky = '{0, 0};
        end else begin
            accept = v && (sb_q.size() == 0 || ordy);
            if (sb_q.size() != 0 && ordy) void'(sb_q.pop_front());
            for (int i = 0; i < 2; i++) begin
                base = c ? 0 : m_acc[i];
                if (c) m_sticky[i] = 1'b0;
                if (accept) begin
                    model_op(accw[i], base, longint'(signed'(8'(d))), s, sm, res, ovf);
                    m_acc[i]    = res;
                    m_sticky[i] = m_sticky[i] | ovf;
                    if (i == 0) begin e.data0 = res; e.ovf0 = ovf; end
                    else        begin e.data1 = res; e.ovf1 = ovf; end
                end else if (c) begin
                    m_acc[i] = 0;
                end
            end
            if (accept) sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (r) initialized = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("sticky%0d", accw[i]), 64'(so[i]), 64'(m_sticky[i]));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        initialized = 1'b0;
        m_acc       = '{0, 0};
        m_sticky    = '{0, 0};
        rst = 1; clear = 0; in_valid = 0; in_data = 0; in_sub = 0; sat_mode = 0; out_ready = 1;
        @(negedge clk);

        // Reset with a valid sample presented: nothing may be accepted.
        applyStimulus(1, 0, 1, 55, 0, 1, 1);
        applyStimulus(1, 0, 1, 55, 0, 1, 1);
        checkOutput("rst_out_data8", od[0], 0);
        checkOutput("rst_out_data12", od[1], 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);

        // Saturating climb to the positive limit.
        applyStimulus(0, 0, 1, 100, 0, 1, 1);
        applyStimulus(0, 0, 1, 27, 0, 1, 1);
        applyStimulus(0, 0, 1, 1, 0, 1, 1);
        checkOutput("t2_sticky8", 64'(so[0]), 1);
        idle(1);

        // Negative limit, subtracting past it in saturate then wrap mode.
        applyStimulus(0, 1, 1, -128, 0, 1, 1);
        applyStimulus(0, 0, 1, 1, 1, 1, 1);
        idle(1);
        applyStimulus(0, 1, 1, -128, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 1, 0, 1);
        idle(1);

        // Backpressure: result held while the next sample waits.
        applyStimulus(0, 1, 1, 5, 0, 1, 1);
        applyStimulus(0, 0, 1, 5, 0, 1, 0);
        applyStimulus(0, 0, 1, 5, 0, 1, 0);
        applyStimulus(0, 0, 1, 5, 0, 1, 0);
        applyStimulus(0, 0, 1, 5, 0, 1, 1);
        idle(1);

        // Clear coinciding with an accept starts from zero and drops sticky.
        applyStimulus(0, 1, 1, 127, 0, 1, 1);
        applyStimulus(0, 0, 1, 1, 0, 1, 1);
        applyStimulus(0, 0, 1, 77, 1, 1, 1);
        applyStimulus(0, 1, 1, 5, 0, 1, 1);
        checkOutput("t5_sticky8", 64'(so[0]), 0);
        idle(1);

        // Long run into the wide accumulator limit, then reset a pending result.
        applyStimulus(0, 1, 0, 0, 0, 1, 1);
        for (int k = 0; k < 17; k++) applyStimulus(0, 0, 1, 127, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        checkOutput("t6_rst_valid12", 64'(ov[1]), 0);
        applyStimulus(0, 0, 1, 3, 0, 1, 1);
        idle(1);

        // Random mix of modes, signs and backpressure.
        for (int k = 0; k < 60; k++) begin
            applyStimulus(0, ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                          int'($urandom_range(0, 255)), $urandom_range(0, 1),
                          $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
